// File: rtl/aes_mode_engine.sv
// Iterative AES-128 encryptor, one round per clock with on-the-fly key expansion.
// The block-cipher mode (ECB, CBC or CTR) is fixed at build time; blocks stream through valid/ready handshakes.
module aes_mode_engine #(
    parameter int MODE      = 0,
    parameter int CTR_WIDTH = 32
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         start,
    input  logic [127:0] key,
    input  logic [127:0] iv,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy,
    output logic [15:0]  block_count
);

    if (!(MODE == 32'sd0 || MODE == 32'sd1 || MODE == 32'sd2)) begin : g_mode_check
        $error("aes_mode_engine: MODE must be 0 (ECB), 1 (CBC) or 2 (CTR)");
    end
    if (CTR_WIDTH < 32'sd8 || CTR_WIDTH > 32'sd128) begin : g_ctr_check
        $error("aes_mode_engine: CTR_WIDTH must lie in 8..128");
    end

    localparam bit IS_CBC = (MODE == 32'sd1);
    localparam bit IS_CTR = (MODE == 32'sd2);
    // A shift of 128 yields zero, so the mask becomes all ones for a full-width counter.
    localparam logic [127:0] CTR_MASK = (128'd1 << CTR_WIDTH) - 128'd1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT_IN, S_ROUND, S_OUT} state_e;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            p = p ^ (x & {8{b[i]}});
            x = xt(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (zero maps to zero), then the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = a;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int w = 0; w < 4; w++) begin
                r[127-8*(w+4*c) -: 8] = sbox(s[127-8*(w+4*((c+w)%4)) -: 8]);
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [127:0] key_next(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] t, w0, w1, w2, w3;
        t  = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])} ^ {rc, 24'h000000};
        w0 = k[127:96] ^ t;
        w1 = k[95:64] ^ w0;
        w2 = k[63:32] ^ w1;
        w3 = k[31:0] ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    state_e        fsm_q;
    logic [127:0]  state_q, rk_q, key_q, chain_q, ctr_q, pt_q, out_data_q;
    logic [3:0]    rnd_q;
    logic [15:0]   count_q;
    logic          in_ready_q, out_valid_q, busy_q;

    logic [127:0]  rk_d, state_d, ctr_d, sr_s, mc_s, x_s;

    // One cipher round plus the matching key-schedule step
    always_comb begin
        rk_d = key_next(rk_q, rcon(rnd_q));
        sr_s = sub_shift(state_q);
        mc_s = {mix_col(sr_s[127:96]), mix_col(sr_s[95:64]), mix_col(sr_s[63:32]), mix_col(sr_s[31:0])};
        if (rnd_q == 4'd10) begin
            state_d = sr_s ^ rk_d;
        end else begin
            state_d = mc_s ^ rk_d;
        end
    end

    // Mode-dependent cipher input and the next counter block
    always_comb begin
        if (IS_CBC) begin
            x_s = in_data ^ chain_q;
        end else if (IS_CTR) begin
            x_s = ctr_q;
        end else begin
            x_s = in_data;
        end
        if (IS_CTR) begin
            ctr_d = (ctr_q & ~CTR_MASK) | ((ctr_q + 128'd1) & CTR_MASK);
        end else begin
            ctr_d = ctr_q;
        end
    end

    // Control FSM with session registers and registered handshake outputs
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            fsm_q       <= S_IDLE;
            state_q     <= '0;
            rk_q        <= '0;
            key_q       <= '0;
            chain_q     <= '0;
            ctr_q       <= '0;
            pt_q        <= '0;
            out_data_q  <= '0;
            rnd_q       <= 4'd0;
            count_q     <= 16'h0000;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else if (start) begin
            key_q       <= key;
            chain_q     <= iv;
            ctr_q       <= iv;
            count_q     <= 16'h0000;
            fsm_q       <= S_WAIT_IN;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (fsm_q)
                S_WAIT_IN: begin
                    if (in_valid) begin
                        state_q    <= x_s ^ key_q;
                        rk_q       <= key_q;
                        rnd_q      <= 4'd1;
                        pt_q       <= in_data;
                        ctr_q      <= ctr_d;
                        fsm_q      <= S_ROUND;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                S_ROUND: begin
                    state_q <= state_d;
                    rk_q    <= rk_d;
                    rnd_q   <= rnd_q + 4'd1;
                    if (rnd_q == 4'd10) begin
                        fsm_q       <= S_OUT;
                        out_valid_q <= 1'b1;
                        out_data_q  <= IS_CTR ? (state_d ^ pt_q) : state_d;
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        if (IS_CBC) begin
                            chain_q <= state_q;
                        end
                        count_q     <= (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
                        fsm_q       <= S_WAIT_IN;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    fsm_q <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign busy        = busy_q;
    assign block_count = count_q;

endmodule

// File: tb/tb_aes_mode_engine.sv
// Bench for aes_mode_engine: ECB, CBC and CTR instances run in lockstep on shared stimulus,
// and a monitor compares their outputs against a queue filled from a behavioural AES model.
module tb_aes_mode_engine;

    logic         clk = 1'b0;
    logic         n_rst;
    logic         start_s;
    logic [127:0] key_s, iv_s, in_data_s;
    logic         in_valid_s, out_ready_s;
    logic         in_ready_s [3];
    logic         out_valid_s [3];
    logic [127:0] out_data_s [3];
    logic         busy_s [3];
    logic [15:0]  block_count_s [3];

    int checks = 0;
    int failures = 0;
    logic [7:0] sb [256];
    logic [2:0][127:0] exp_q [$];
    int exp_cnt = 0;
    int cyc = 0;
    int hold_until = 0;
    bit bp_rand = 1'b0;
    logic [127:0] m_key, m_chain, m_ctr;

    localparam logic [127:0] KEY1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] KEY2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P1   = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] P2   = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    localparam logic [127:0] IVC  = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        aes_mode_engine #(.MODE(g), .CTR_WIDTH(32)) u_dut (
            .clk        (clk),
            .n_rst      (n_rst),
            .start      (start_s),
            .key        (key_s),
            .iv         (iv_s),
            .in_valid   (in_valid_s),
            .in_ready   (in_ready_s[g]),
            .in_data    (in_data_s),
            .out_valid  (out_valid_s[g]),
            .out_ready  (out_ready_s),
            .out_data   (out_data_s[g]),
            .busy       (busy_s[g]),
            .block_count(block_count_s[g])
        );
    end

    task automatic chk(input bit ok, input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        while (bb != 8'h00) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    // S-box from its definition: brute-force field inverse, then the FIPS-197 affine bit formula.
    task automatic build_sbox();
        logic [7:0] inv, s, c;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(x[7:0], y[7:0]) == 8'h01) inv = y[7:0];
            end
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
            sb[x] = s;
        end
    endtask

    function automatic logic [127:0] aes_enc(input logic [127:0] k, input logic [127:0] p);
        logic [31:0]  w [44];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [31:0]  tmp;
        logic [7:0]   rc;
        logic [127:0] res;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h000000};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = p[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sb[s[(i%4) + 4*(((i/4) + (i%4)) % 4)]];
            for (int c = 0; c < 4; c++) begin
                if (r < 10) begin
                    s[4*c]   = gmul(t[4*c], 8'h02) ^ gmul(t[4*c+1], 8'h03) ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 8'h02) ^ gmul(t[4*c+2], 8'h03) ^ t[4*c+3];
                    s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 8'h02) ^ gmul(t[4*c+3], 8'h03);
                    s[4*c+3] = gmul(t[4*c], 8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 8'h02);
                end else begin
                    for (int j = 0; j < 4; j++) s[4*c+j] = t[4*c+j];
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    task automatic do_start(input logic [127:0] k, input logic [127:0] v);
        @(negedge clk);
        key_s = k; iv_s = v; start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        m_key = k; m_chain = v; m_ctr = v; exp_cnt = 0;
    endtask

    task automatic wait_in_ready(output bit ok);
        int n = 0;
        while (in_ready_s[0] !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        ok = (in_ready_s[0] === 1'b1);
        chk(ok, "in_ready_timeout", {96'd0, n}, 128'd200);
    endtask

    // Push the expectation for each mode (known vector or model), then hand the block over.
    task automatic send_block(input logic [127:0] pt, input logic [2:0] known,
                              input logic [127:0] k0, input logic [127:0] k1, input logic [127:0] k2);
        logic [2:0][127:0] e;
        bit ok;
        int lat;
        e[0] = known[0] ? k0 : aes_enc(m_key, pt);
        e[1] = known[1] ? k1 : aes_enc(m_key, pt ^ m_chain);
        e[2] = known[2] ? k2 : (aes_enc(m_key, m_ctr) ^ pt);
        m_chain = e[1];
        m_ctr   = {m_ctr[127:32], m_ctr[31:0] + 32'd1};
        exp_q.push_back(e);
        @(negedge clk);
        in_data_s = pt; in_valid_s = 1'b1;
        wait_in_ready(ok);
        if (!ok) begin
            in_valid_s = 1'b0;
            return;
        end
        @(posedge clk); #1;
        in_valid_s = 1'b0;
        lat = 0;
        while (out_valid_s[0] !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk(lat == 10, "latency", {96'd0, lat}, 128'd10);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk(exp_q.size() == 0, "drain_timeout", {96'd0, exp_q.size()}, 128'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin : ready_drv
        out_ready_s = 1'b1;
        forever begin
            @(posedge clk); #2;
            cyc++;
            if (cyc < hold_until) out_ready_s = 1'b0;
            else if (bp_rand) out_ready_s = 1'($urandom_range(0, 1));
            else out_ready_s = 1'b1;
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (n_rst === 1'b1 && (out_valid_s[0] || out_valid_s[1] || out_valid_s[2])) begin
                chk(!(in_ready_s[0] || in_ready_s[1] || in_ready_s[2]), "ready_and_valid", 128'd1, 128'd0);
                if (exp_q.size() == 0) begin
                    chk(1'b0, "unexpected_out", out_data_s[0], 128'd0);
                end else begin
                    for (int m = 0; m < 3; m++)
                        chk(out_valid_s[m] === 1'b1 && out_data_s[m] === exp_q[0][m],
                            $sformatf("out_data_m%0d", m), out_data_s[m], exp_q[0][m]);
                    if (out_ready_s) begin
                        for (int m = 0; m < 3; m++)
                            chk(block_count_s[m] === exp_cnt[15:0], $sformatf("block_count_m%0d", m),
                                {112'd0, block_count_s[m]}, {112'd0, exp_cnt[15:0]});
                        exp_cnt++;
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin : guard
        #600000;
        $display("FAIL global_timeout actual=%0t required=finish", $time);
        $fatal(1, "bench timeout");
    end

    initial begin : stim
        bit ok;
        logic [127:0] rk, rv;
        n_rst = 1'b0; start_s = 1'b0; key_s = '0; iv_s = '0; in_data_s = '0; in_valid_s = 1'b0;
        build_sbox();
        repeat (3) @(negedge clk);
        for (int m = 0; m < 3; m++) begin
            chk(in_ready_s[m] === 1'b0 && out_valid_s[m] === 1'b0 && busy_s[m] === 1'b0, "rst_flags",
                {125'd0, in_ready_s[m], out_valid_s[m], busy_s[m]}, 128'd0);
            chk(block_count_s[m] === 16'h0000, "rst_count", {112'd0, block_count_s[m]}, 128'd0);
            chk(out_data_s[m] === 128'd0, "rst_out_data", out_data_s[m], 128'd0);
        end
        n_rst = 1'b1;
        repeat (2) @(negedge clk);
        chk(in_ready_s[0] === 1'b0, "idle_in_ready", {127'd0, in_ready_s[0]}, 128'd0);

        // FIPS-197 single block
        do_start(KEY1, 128'd0);
        send_block(PT1, 3'b001, CT1, 128'd0, 128'd0);
        wait_drain();
        for (int m = 0; m < 3; m++)
            chk(block_count_s[m] === 16'd1, "count_after_one", {112'd0, block_count_s[m]}, 128'd1);

        // SP800-38A ECB/CBC with a stalled first output
        do_start(KEY2, KEY1);
        hold_until = cyc + 18;
        send_block(P1, 3'b011, 128'h3ad77bb40d7a3660a89ecaf32466ef97, 128'h7649abac8119b246cee98e9b12e9197d, 128'd0);
        send_block(P2, 3'b011, 128'hf5d3d58503b9699de785895a96fdbaaf, 128'h5086cb9b507219ee95db113a917678b2, 128'd0);
        wait_drain();

        // SP800-38A CTR
        do_start(KEY2, IVC);
        send_block(P1, 3'b101, 128'h3ad77bb40d7a3660a89ecaf32466ef97, 128'd0, 128'h874d6191b620e3261bef6864990db6ce);
        send_block(P2, 3'b101, 128'hf5d3d58503b9699de785895a96fdbaaf, 128'd0, 128'h9806f66b7970fdff8617187bb9fffdff);
        wait_drain();

        // Abort a block at round 5 with a new start, then run the FIPS block under the new key
        @(negedge clk);
        in_data_s = {$urandom, $urandom, $urandom, $urandom}; in_valid_s = 1'b1;
        wait_in_ready(ok);
        @(posedge clk); #1;
        in_valid_s = 1'b0;
        repeat (5) @(negedge clk);
        key_s = KEY1; iv_s = 128'd0; start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        m_key = KEY1; m_chain = 128'd0; m_ctr = 128'd0; exp_cnt = 0;
        for (int m = 0; m < 3; m++) begin
            chk(block_count_s[m] === 16'h0000, "abort_count", {112'd0, block_count_s[m]}, 128'd0);
            chk(in_ready_s[m] === 1'b1 && busy_s[m] === 1'b0 && out_valid_s[m] === 1'b0, "abort_flags",
                {125'd0, in_ready_s[m], busy_s[m], out_valid_s[m]}, 128'd4);
        end
        send_block(PT1, 3'b001, CT1, 128'd0, 128'd0);
        wait_drain();

        // Random sessions with output backpressure; the last one crosses the 32-bit counter wrap
        bp_rand = 1'b1;
        for (int s = 0; s < 3; s++) begin
            rk = {$urandom, $urandom, $urandom, $urandom};
            rv = {$urandom, $urandom, $urandom, $urandom};
            if (s == 2) rv[31:0] = 32'hFFFFFFFE;
            do_start(rk, rv);
            for (int b = 0; b < 4; b++)
                send_block({$urandom, $urandom, $urandom, $urandom}, 3'b000, 128'd0, 128'd0, 128'd0);
            wait_drain();
        end
        bp_rand = 1'b0;

        // Asynchronous reset in the middle of a round
        do_start({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
        @(negedge clk);
        in_data_s = {$urandom, $urandom, $urandom, $urandom}; in_valid_s = 1'b1;
        wait_in_ready(ok);
        @(posedge clk); #1;
        in_valid_s = 1'b0;
        repeat (3) @(posedge clk);
        #3 n_rst = 1'b0;
        #1;
        for (int m = 0; m < 3; m++)
            chk(in_ready_s[m] === 1'b0 && out_valid_s[m] === 1'b0 && busy_s[m] === 1'b0, "async_rst_flags",
                {125'd0, in_ready_s[m], out_valid_s[m], busy_s[m]}, 128'd0);
        exp_q.delete();
        exp_cnt = 0;
        @(negedge clk);
        n_rst = 1'b1;
        repeat (4) @(negedge clk);
        for (int m = 0; m < 3; m++)
            chk(in_ready_s[m] === 1'b0 && busy_s[m] === 1'b0, "post_rst_idle",
                {126'd0, in_ready_s[m], busy_s[m]}, 128'd0);
        do_start(KEY1, 128'd0);
        chk(in_ready_s[0] === 1'b1, "restart_in_ready", {127'd0, in_ready_s[0]}, 128'd1);
        send_block(PT1, 3'b001, CT1, 128'd0, 128'd0);
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
